// File: rtl/shift_arbiter.sv
// Two-requester round-robin arbiter sharing one SLL and one SRA barrel shifter,
// with a one-entry registered result stage that supports backpressure.

module barrel_sll (
  input  logic [31:0] data,
  input  logic [4:0]  shamt,
  output logic [31:0] result
);
  logic [31:0] stage;

  always_comb begin
    stage = data;
    if (shamt[0]) stage = {stage[30:0], 1'b0};
    if (shamt[1]) stage = {stage[29:0], 2'b0};
    if (shamt[2]) stage = {stage[27:0], 4'b0};
    if (shamt[3]) stage = {stage[23:0], 8'b0};
    if (shamt[4]) stage = {stage[15:0], 16'b0};
    result = stage;
  end
endmodule

module barrel_sra (
  input  logic [31:0] data,
  input  logic [4:0]  shamt,
  output logic [31:0] result
);
  logic [31:0] stage;
  logic        sign;

  always_comb begin
    sign  = data[31];
    stage = data;
    if (shamt[0]) stage = {{1{sign}},  stage[31:1]};
    if (shamt[1]) stage = {{2{sign}},  stage[31:2]};
    if (shamt[2]) stage = {{4{sign}},  stage[31:4]};
    if (shamt[3]) stage = {{8{sign}},  stage[31:8]};
    if (shamt[4]) stage = {{16{sign}}, stage[31:16]};
    result = stage;
  end
endmodule

module shift_arbiter #(
  parameter int FIXED_PRIO = 0
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid_0,
  input  logic        req_valid_1,
  output logic        req_ready_0,
  output logic        req_ready_1,
  input  logic [31:0] req_data_0,
  input  logic [31:0] req_data_1,
  input  logic [4:0]  req_shamt_0,
  input  logic [4:0]  req_shamt_1,
  input  logic        req_op_0,
  input  logic        req_op_1,
  output logic        rsp_valid_0,
  output logic        rsp_valid_1,
  input  logic        rsp_ready_0,
  input  logic        rsp_ready_1,
  output logic [31:0] rsp_result
);
  // Handshake: a request transfers on a rising edge where req_valid_k & req_ready_k;
  // a response is consumed where rsp_valid_k & rsp_ready_k. Ready may depend on valid.
  localparam logic EMPTY = 1'b0;
  localparam logic FULL  = 1'b1;

  logic        state;
  logic        out_owner;
  logic [31:0] out_result;
  logic        last_grant;

  logic        grant_0, grant_1;
  logic        owner_ready, can_accept, accept;
  logic [31:0] sel_data, sll_out, sra_out, shift_out;
  logic [4:0]  sel_shamt;
  logic        sel_op;

  // On a tie, round-robin favours whoever did not win last; fixed mode favours 0.
  always_comb begin
    grant_0 = 1'b0;
    grant_1 = 1'b0;
    if (req_valid_0 && req_valid_1) begin
      if (FIXED_PRIO != 0) grant_0 = 1'b1;
      else if (last_grant) grant_0 = 1'b1;
      else grant_1 = 1'b1;
    end else begin
      grant_0 = req_valid_0;
      grant_1 = req_valid_1;
    end
  end

  assign owner_ready = out_owner ? rsp_ready_1 : rsp_ready_0;
  assign can_accept  = reset_n && ((state == EMPTY) || owner_ready);
  assign req_ready_0 = grant_0 && can_accept;
  assign req_ready_1 = grant_1 && can_accept;
  assign accept      = req_ready_0 || req_ready_1;

  assign sel_data  = grant_1 ? req_data_1  : req_data_0;
  assign sel_shamt = grant_1 ? req_shamt_1 : req_shamt_0;
  assign sel_op    = grant_1 ? req_op_1    : req_op_0;

  barrel_sll u_sll (.data(sel_data), .shamt(sel_shamt), .result(sll_out));
  barrel_sra u_sra (.data(sel_data), .shamt(sel_shamt), .result(sra_out));

  assign shift_out = sel_op ? sra_out : sll_out;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= EMPTY;
      out_owner  <= 1'b0;
      out_result <= 32'd0;
      last_grant <= 1'b1;
    end else begin
      if (accept) begin
        state      <= FULL;
        out_owner  <= grant_1;
        out_result <= shift_out;
        last_grant <= grant_1;
      end else if (state == FULL && owner_ready) begin
        state <= EMPTY;
      end
    end
  end

  assign rsp_valid_0 = (state == FULL) && !out_owner;
  assign rsp_valid_1 = (state == FULL) && out_owner;
  assign rsp_result  = out_result;
endmodule

// File: tb/tb_shift_arbiter.sv
// Directed bench for shift_arbiter: a round-robin instance and a fixed-priority
// instance share the same stimulus; expected values are hand-computed constants.

module tb_shift_arbiter;
  logic        clock;
  logic        reset_n;
  logic        req_valid_0, req_valid_1;
  logic [31:0] req_data_0, req_data_1;
  logic [4:0]  req_shamt_0, req_shamt_1;
  logic        req_op_0, req_op_1;
  logic        rsp_ready_0, rsp_ready_1;

  logic        req_ready_0, req_ready_1, rsp_valid_0, rsp_valid_1;
  logic [31:0] rsp_result;
  logic        fp_req_ready_0, fp_req_ready_1, fp_rsp_valid_0, fp_rsp_valid_1;
  logic [31:0] fp_rsp_result;

  int n_checks = 0;
  int n_errors = 0;

  shift_arbiter #(.FIXED_PRIO(0)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid_0(req_valid_0), .req_valid_1(req_valid_1),
    .req_ready_0(req_ready_0), .req_ready_1(req_ready_1),
    .req_data_0(req_data_0), .req_data_1(req_data_1),
    .req_shamt_0(req_shamt_0), .req_shamt_1(req_shamt_1),
    .req_op_0(req_op_0), .req_op_1(req_op_1),
    .rsp_valid_0(rsp_valid_0), .rsp_valid_1(rsp_valid_1),
    .rsp_ready_0(rsp_ready_0), .rsp_ready_1(rsp_ready_1),
    .rsp_result(rsp_result)
  );

  shift_arbiter #(.FIXED_PRIO(1)) dut_fp (
    .clock(clock), .reset_n(reset_n),
    .req_valid_0(req_valid_0), .req_valid_1(req_valid_1),
    .req_ready_0(fp_req_ready_0), .req_ready_1(fp_req_ready_1),
    .req_data_0(req_data_0), .req_data_1(req_data_1),
    .req_shamt_0(req_shamt_0), .req_shamt_1(req_shamt_1),
    .req_op_0(req_op_0), .req_op_1(req_op_1),
    .rsp_valid_0(fp_rsp_valid_0), .rsp_valid_1(fp_rsp_valid_1),
    .rsp_ready_0(rsp_ready_0), .rsp_ready_1(rsp_ready_1),
    .rsp_result(fp_rsp_result)
  );

  // Clock and reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Checking task
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    req_valid_0 = 1'b0; req_data_0 = '0; req_shamt_0 = '0; req_op_0 = 1'b0;
    req_valid_1 = 1'b0; req_data_1 = '0; req_shamt_1 = '0; req_op_1 = 1'b0;
  endtask

  task automatic drive_0(input logic v, input logic [31:0] d, input logic [4:0] s, input logic op);
    req_valid_0 = v; req_data_0 = d; req_shamt_0 = s; req_op_0 = op;
  endtask

  task automatic drive_1(input logic v, input logic [31:0] d, input logic [4:0] s, input logic op);
    req_valid_1 = v; req_data_1 = d; req_shamt_1 = s; req_op_1 = op;
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
  endtask

  initial begin
    idle();
    rsp_ready_0 = 1'b0;
    rsp_ready_1 = 1'b0;
    reset_n = 1'b0;

    // Reset state, including ready forced low despite a valid request
    drive_0(1'b1, 32'h1, 5'd1, 1'b0);
    #2;
    check("reset_rsp_valid_0", {31'd0, rsp_valid_0}, 32'd0);
    check("reset_rsp_valid_1", {31'd0, rsp_valid_1}, 32'd0);
    check("reset_req_ready_0", {31'd0, req_ready_0}, 32'd0);
    check("reset_rsp_result", rsp_result, 32'd0);
    idle();
    #10;
    reset_n = 1'b1;
    step();

    // Single SLL on requester 0
    drive_0(1'b1, 32'h0000_0001, 5'd4, 1'b0);
    rsp_ready_0 = 1'b1;
    #2;
    check("sll_req_ready_0", {31'd0, req_ready_0}, 32'd1);
    check("sll_req_ready_1", {31'd0, req_ready_1}, 32'd0);
    step();
    idle();
    #2;
    check("sll_rsp_valid_0", {31'd0, rsp_valid_0}, 32'd1);
    check("sll_rsp_valid_1", {31'd0, rsp_valid_1}, 32'd0);
    check("sll_result", rsp_result, 32'h0000_0010);
    step();
    check("sll_drained", {31'd0, rsp_valid_0}, 32'd0);

    // SRA sign fill, back-to-back on requester 1
    rsp_ready_1 = 1'b1;
    drive_1(1'b1, 32'h8000_0000, 5'd4, 1'b1);
    #2;
    check("sra1_req_ready_1", {31'd0, req_ready_1}, 32'd1);
    step();
    drive_1(1'b1, 32'h7FFF_FFF0, 5'd31, 1'b1);
    #2;
    check("sra1_rsp_valid_1", {31'd0, rsp_valid_1}, 32'd1);
    check("sra1_result", rsp_result, 32'hF800_0000);
    check("sra2_req_ready_1", {31'd0, req_ready_1}, 32'd1);
    step();
    drive_1(1'b1, 32'h1234_5678, 5'd0, 1'b1);
    #2;
    check("sra2_result", rsp_result, 32'h0000_0000);
    check("sra3_req_ready_1", {31'd0, req_ready_1}, 32'd1);
    step();
    idle();
    #2;
    check("sra3_result", rsp_result, 32'h1234_5678);
    check("sra3_rsp_valid_1", {31'd0, rsp_valid_1}, 32'd1);
    step();
    check("sra_drained", {31'd0, rsp_valid_1}, 32'd0);

    // Round-robin vs fixed priority under a both-valid load
    pulse_reset();
    rsp_ready_0 = 1'b1;
    rsp_ready_1 = 1'b1;
    drive_0(1'b1, 32'h1, 5'd1, 1'b0);
    drive_1(1'b1, 32'h1, 5'd2, 1'b0);
    for (int i = 0; i < 4; i++) begin
      #2;
      check("rr_req_ready_0", {31'd0, req_ready_0}, (i % 2 == 0) ? 32'd1 : 32'd0);
      check("rr_req_ready_1", {31'd0, req_ready_1}, (i % 2 == 1) ? 32'd1 : 32'd0);
      check("fp_req_ready_0", {31'd0, fp_req_ready_0}, 32'd1);
      check("fp_req_ready_1", {31'd0, fp_req_ready_1}, 32'd0);
      step();
      check("rr_rsp_valid_0", {31'd0, rsp_valid_0}, (i % 2 == 0) ? 32'd1 : 32'd0);
      check("rr_rsp_valid_1", {31'd0, rsp_valid_1}, (i % 2 == 1) ? 32'd1 : 32'd0);
      check("rr_result", rsp_result, (i % 2 == 0) ? 32'h2 : 32'h4);
      check("fp_rsp_valid_1", {31'd0, fp_rsp_valid_1}, 32'd0);
      check("fp_result", fp_rsp_result, 32'h2);
    end
    idle();
    step();

    // Backpressure: owner 0 stalls while requester 1 waits
    pulse_reset();
    rsp_ready_0 = 1'b0;
    rsp_ready_1 = 1'b1;
    drive_0(1'b1, 32'h3, 5'd1, 1'b0);
    step();
    idle();
    drive_1(1'b1, 32'h5, 5'd1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #2;
      check("bp_req_ready_0", {31'd0, req_ready_0}, 32'd0);
      check("bp_req_ready_1", {31'd0, req_ready_1}, 32'd0);
      check("bp_rsp_valid_0", {31'd0, rsp_valid_0}, 32'd1);
      check("bp_result", rsp_result, 32'h6);
      step();
    end
    rsp_ready_0 = 1'b1;
    #2;
    check("bp_release_req_ready_1", {31'd0, req_ready_1}, 32'd1);
    step();
    idle();
    #2;
    check("bp_rsp_valid_1", {31'd0, rsp_valid_1}, 32'd1);
    check("bp_rsp_valid_0", {31'd0, rsp_valid_0}, 32'd0);
    check("bp_result_1", rsp_result, 32'hA);
    step();

    // Non-owner ready ignored: owner 1 stalls, requester 0's ready must not drain it
    rsp_ready_0 = 1'b1;
    rsp_ready_1 = 1'b0;
    drive_1(1'b1, 32'h7, 5'd0, 1'b1);
    step();
    idle();
    drive_0(1'b1, 32'h9, 5'd2, 1'b0);
    #2;
    check("no_req_ready_0", {31'd0, req_ready_0}, 32'd0);
    check("no_rsp_valid_1", {31'd0, rsp_valid_1}, 32'd1);
    check("no_result", rsp_result, 32'h7);
    step();
    check("no_hold_valid_1", {31'd0, rsp_valid_1}, 32'd1);
    check("no_hold_result", rsp_result, 32'h7);

    // Reset mid-operation while FULL, then the first tie goes to requester 0
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_reset_rsp_valid_1", {31'd0, rsp_valid_1}, 32'd0);
    check("mid_reset_result", rsp_result, 32'd0);
    check("mid_reset_req_ready_0", {31'd0, req_ready_0}, 32'd0);
    #1;
    reset_n = 1'b1;
    drive_1(1'b1, 32'h1, 5'd3, 1'b0);
    rsp_ready_1 = 1'b1;
    #1;
    check("post_reset_req_ready_0", {31'd0, req_ready_0}, 32'd1);
    check("post_reset_req_ready_1", {31'd0, req_ready_1}, 32'd0);
    step();
    check("post_reset_result", rsp_result, 32'h24);
    check("post_reset_rsp_valid_0", {31'd0, rsp_valid_0}, 32'd1);
    idle();
    step();

    // Final report
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
